// File: rtl/pipe_pkg.sv
// pipe_pkg: shared MIPS pipeline widths, control bundle type and zero-register constant
package pipe_pkg;
  localparam int DW = 32;
  localparam int RA_W = 5;
  localparam int CTRL_W = 32;
  localparam int REG_ZERO = 0;
  typedef logic [CTRL_W-1:0] ctrl_t;
endpackage

// File: rtl/fwd_select.sv
// fwd_select: priority operand matcher over forwarding sources; ID_FORWARD_EN enables bypass
module fwd_select #(
  parameter int DW = pipe_pkg::DW,
  parameter int RA_W = pipe_pkg::RA_W,
  parameter int NUM_FWD = 3
) (
  input  logic [RA_W-1:0]         src,
  input  logic                    use_src,
  input  logic [DW-1:0]           rf,
  input  logic [NUM_FWD-1:0]      fwd_wr,
  input  logic [NUM_FWD*RA_W-1:0] fwd_reg,
  input  logic [NUM_FWD-1:0]      fwd_pend,
  input  logic [NUM_FWD*DW-1:0]   fwd_data,
  output logic [DW-1:0]           val,
  output logic                    pend
);
  import pipe_pkg::*;
  logic zero;
  assign zero = src == RA_W'(REG_ZERO);
`ifdef ID_FORWARD_EN
  logic [DW-1:0] sel_val;
  logic          sel_pend;
  // scan oldest to youngest so the lowest matching index wins
  always_comb begin
    sel_val = rf;
    sel_pend = 1'b0;
    for (int k = NUM_FWD - 1; k >= 0; k--)
      if (fwd_wr[k] && fwd_reg[k*RA_W +: RA_W] == src) begin
        sel_val = fwd_data[k*DW +: DW];
        sel_pend = fwd_pend[k];
      end
    val = zero ? '0 : sel_val;
    pend = use_src && !zero && sel_pend;
  end
`else
  logic hit;
  logic unused_ok;
  assign unused_ok = ^{fwd_pend, fwd_data};
  // without bypass any in-flight writer of the source must drain first
  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < NUM_FWD; k++)
      hit = hit | (fwd_wr[k] && fwd_reg[k*RA_W +: RA_W] == src);
    val = zero ? '0 : rf;
    pend = use_src && !zero && hit;
  end
`endif
endmodule

// File: rtl/id_operand_stage.sv
// id_operand_stage: operand resolve, interlock and ID/EX register; ID_FORWARD_EN enables bypass
module id_operand_stage #(
  parameter int DW = pipe_pkg::DW,
  parameter int RA_W = pipe_pkg::RA_W,
  parameter int NUM_FWD = 3,
  parameter int CTRL_W = pipe_pkg::CTRL_W,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [31:0]             i_pc,
  input  logic [RA_W-1:0]         i_rs,
  input  logic [RA_W-1:0]         i_rt,
  input  logic                    i_use_rs,
  input  logic                    i_use_rt,
  input  logic [RA_W-1:0]         i_rn,
  input  logic [DW-1:0]           i_imm,
  input  logic [CTRL_W-1:0]       i_ctrl,
  input  logic [DW-1:0]           qa,
  input  logic [DW-1:0]           qb,
  input  logic [NUM_FWD-1:0]      fwd_wr,
  input  logic [NUM_FWD*RA_W-1:0] fwd_reg,
  input  logic [NUM_FWD-1:0]      fwd_pend,
  input  logic [NUM_FWD*DW-1:0]   fwd_data,
  input  logic                    i_flush,
  input  logic                    ex_ready,
  output logic                    ex_valid,
  output logic [31:0]             ex_pc,
  output logic [DW-1:0]           ex_da,
  output logic [DW-1:0]           ex_db,
  output logic [DW-1:0]           ex_imm,
  output logic [RA_W-1:0]         ex_rn,
  output logic [CTRL_W-1:0]       ex_ctrl,
  output logic [DW-1:0]           o_jrpc,
  output logic                    o_rs_eq_rt,
  output logic                    o_hazard,
  output logic [CNT_W-1:0]        o_stall_cnt
);
  localparam int EW = 32 + 3 * DW + RA_W + CTRL_W;
  logic [DW-1:0]    val_a, val_b;
  logic             haz_a, haz_b, adv;
  logic             ex_valid_q, ex_valid_d;
  logic [EW-1:0]    ex_q, ex_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  fwd_select #(.DW(DW), .RA_W(RA_W), .NUM_FWD(NUM_FWD)) u_rs (
    .src(i_rs), .use_src(i_use_rs), .rf(qa), .fwd_wr(fwd_wr), .fwd_reg(fwd_reg),
    .fwd_pend(fwd_pend), .fwd_data(fwd_data), .val(val_a), .pend(haz_a)
  );
  fwd_select #(.DW(DW), .RA_W(RA_W), .NUM_FWD(NUM_FWD)) u_rt (
    .src(i_rt), .use_src(i_use_rt), .rf(qb), .fwd_wr(fwd_wr), .fwd_reg(fwd_reg),
    .fwd_pend(fwd_pend), .fwd_data(fwd_data), .val(val_b), .pend(haz_b)
  );
  assign o_hazard = i_valid && (haz_a || haz_b);
  assign adv = !ex_valid_q || ex_ready;
  assign o_ready = i_valid && !o_hazard && adv && !i_flush;
  assign o_jrpc = val_a;
  assign o_rs_eq_rt = val_a == val_b;
  assign ex_valid = ex_valid_q;
  assign {ex_pc, ex_da, ex_db, ex_imm, ex_rn, ex_ctrl} = ex_q;
  assign o_stall_cnt = stall_cnt_q;
  // flush beats advance beats hold; a flushed hazard cycle is not counted as a stall
  always_comb begin
    ex_valid_d = i_flush ? 1'b0 : adv ? o_ready : ex_valid_q;
    ex_d = (!i_flush && adv) ? {i_pc, val_a, val_b, i_imm, i_rn, i_ctrl} : ex_q;
    stall_cnt_d = (o_hazard && !i_flush && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  end
  // ID/EX register and stall counter
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ex_valid_q <= 1'b0;
      ex_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_q <= ex_d;
      stall_cnt_q <= stall_cnt_d;
    end
endmodule
